// File: rtl/hist_readout_ctrl.sv
// Histogram lane readout initiator: muxes live events with a credit-paced bin sweep
// into a FWFT buffer feeding an AXI-Stream master. Optional HIST_READOUT_BIN_INDEX_EN adds m_axis_tuser.
module hist_readout_ctrl #(
   parameter int HIST_MEM_DEPTH      = 4096,
   parameter int HIST_WORD_SIZE      = 32,
   parameter int HIST_MEM_ADDR_WIDTH = $clog2(HIST_MEM_DEPTH),
   parameter int FIFO_DEPTH          = 8,
   parameter int DROP_CNT_WIDTH      = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [HIST_MEM_ADDR_WIDTH-1:0] evt_address,
   input  logic                           evt_valid,
   input  logic                           start,
   input  logic                           clear_after_read,
   output logic                           busy,
   output logic                           done,
   output logic [DROP_CNT_WIDTH-1:0]      dropped_events,
   output logic [HIST_MEM_ADDR_WIDTH-1:0] lane_address,
   output logic                           lane_valid,
   output logic                           lane_hist_read,
   output logic                           lane_hist_rst,
   input  logic [HIST_WORD_SIZE-1:0]      lane_data,
   input  logic                           lane_valid_out,
   input  logic                           lane_last,
   output logic [HIST_WORD_SIZE-1:0]      m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast
`ifdef HIST_READOUT_BIN_INDEX_EN
   ,
   output logic [HIST_MEM_ADDR_WIDTH-1:0] m_axis_tuser
`endif
);
   localparam int AW = HIST_MEM_ADDR_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
`ifdef HIST_READOUT_BIN_INDEX_EN
   localparam int EW = HIST_WORD_SIZE + 1 + AW;
`else
   localparam int EW = HIST_WORD_SIZE + 1;
`endif
   localparam logic [AW-1:0] LAST_BIN = AW'(HIST_MEM_DEPTH - 1);
   localparam logic [CW:0]   CREDITS  = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, QUIESCE, SWEEP, DRAIN, GAP} state_t;
   state_t state, state_n;

   logic          q_cnt, clr, issue, push, pop;
   logic [AW-1:0] bin, ret_bin;
   logic [CW-1:0] fifo_count, in_flight;
   logic [CW:0]   credit_used;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [EW-1:0] head, wr_entry;

   assign busy          = (state != IDLE);
   assign push          = lane_valid_out && (state == SWEEP || state == DRAIN);
   assign m_axis_tvalid = (fifo_count != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign credit_used   = {1'b0, fifo_count} + {1'b0, in_flight};
   assign head          = fifo_mem[rd_ptr];
   assign m_axis_tdata  = m_axis_tvalid ? head[HIST_WORD_SIZE-1:0] : '0;
   assign m_axis_tlast  = m_axis_tvalid & head[HIST_WORD_SIZE];
`ifdef HIST_READOUT_BIN_INDEX_EN
   // Returned beats arrive in issue order, so the return counter is the bin index.
   assign wr_entry      = {ret_bin, lane_last, lane_data};
   assign m_axis_tuser  = m_axis_tvalid ? head[EW-1 -: AW] : '0;
`else
   assign wr_entry      = {lane_last, lane_data};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n        = state;
      lane_address   = evt_address;
      lane_valid     = 1'b0;
      lane_hist_read = 1'b0;
      lane_hist_rst  = 1'b0;
      issue          = 1'b0;
      done           = 1'b0;
      case (state)
         IDLE: begin
            lane_valid = evt_valid;
            if (start) state_n = QUIESCE;
         end
         QUIESCE: if (q_cnt) state_n = SWEEP;
         SWEEP: begin
            lane_hist_read = 1'b1;
            lane_hist_rst  = clr;
            lane_address   = bin;
            // Only issue when the buffer can absorb every outstanding return.
            if (credit_used < CREDITS) begin
               issue      = 1'b1;
               lane_valid = 1'b1;
               if (bin == LAST_BIN) state_n = DRAIN;
            end
         end
         DRAIN: begin
            lane_hist_read = 1'b1;
            lane_hist_rst  = clr;
            if (in_flight == '0 && fifo_count == '0) begin
               done    = 1'b1;
               state_n = GAP;
            end
         end
         GAP:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_cnt          <= 1'b0;
         clr            <= 1'b0;
         bin            <= '0;
         ret_bin        <= '0;
         in_flight      <= '0;
         fifo_count     <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         dropped_events <= '0;
      end else begin
         if (state == IDLE && start) begin
            clr     <= clear_after_read;
            bin     <= '0;
            ret_bin <= '0;
            q_cnt   <= 1'b0;
         end
         if (state == QUIESCE) q_cnt   <= 1'b1;
         if (issue)            bin     <= bin + AW'(1);
         if (push)             ret_bin <= ret_bin + AW'(1);
         if (push)             wr_ptr  <= wr_ptr + PW'(1);
         if (pop)              rd_ptr  <= rd_ptr + PW'(1);
         in_flight  <= in_flight + CW'(issue) - CW'(push);
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         if (busy && evt_valid && dropped_events != '1)
            dropped_events <= dropped_events + DROP_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wr_entry;
   end

   a_tlast_bin: assert property (@(posedge clk) disable iff (!rst_n)
      push |-> (lane_last == (ret_bin == LAST_BIN)));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (push && !pop) |-> (fifo_count < CW'(FIFO_DEPTH)));
endmodule

// File: doc/hist_readout_ctrl.md
Name: hist_readout_ctrl

Overview:
Readout initiator for one histogram lane. It owns the lane's address/valid/hist_read/hist_rst inputs and muxes between the live event stream and a sequential bin sweep. On a start request it quiesces the lane, sweeps bins 0..HIST_MEM_DEPTH-1, optionally clearing each bin as it is read, and buffers the returned counts into an AXI-Stream master with tlast on the final bin. It sits between the event-address pipeline and the lane, with the stream output going to the host link.

Parameters:
HIST_MEM_DEPTH, 4096, number of bins in the lane.
HIST_WORD_SIZE, 32, bin count width; equals the tdata width.
HIST_MEM_ADDR_WIDTH, $clog2(HIST_MEM_DEPTH), bin address width.
FIFO_DEPTH, 8, output buffer entries; power of two, minimum 4.
DROP_CNT_WIDTH, 32, width of the dropped-event counter.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous active-low reset.
evt_address  in  HIST_MEM_ADDR_WIDTH  live event bin address.
evt_valid  in  1  live event qualifier.
start  in  1  one-cycle readout request; ignored unless idle.
clear_after_read  in  1  sampled with start; 1 = zero each bin as it is read.
busy  out  1  high from accepted start until done.
done  out  1  one-cycle pulse when the last beat is accepted.
dropped_events  out  DROP_CNT_WIDTH  saturating count of evt_valid cycles blocked while busy.
lane_address  out  HIST_MEM_ADDR_WIDTH  to lane address_in.
lane_valid  out  1  to lane valid_in.
lane_hist_read  out  1  to lane hist_read.
lane_hist_rst  out  1  to lane hist_rst.
lane_data  in  HIST_WORD_SIZE  from lane data_out.
lane_valid_out  in  1  from lane valid_out.
lane_last  in  1  from lane last_sample.
m_axis_tdata  out  HIST_WORD_SIZE  bin count.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
m_axis_tlast  out  1  marks bin HIST_MEM_DEPTH-1.

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; dropped_events 0.
- IDLE: lane_address = evt_address and lane_valid = evt_valid, combinational pass-through; hist_read = hist_rst = 0. An accepted start latches clear_after_read, sets busy the next cycle, and moves to QUIESCE.
- QUIESCE: 2 cycles with lane_valid = 0 and hist_read = 0, so in-flight lane write-backs complete. Then go to SWEEP with bin counter = 0.
- SWEEP: lane_hist_read = 1 and lane_hist_rst = the latched clear flag. Issue lane_valid = 1 with lane_address = bin only when fifo_count + in_flight < FIFO_DEPTH; otherwise insert a bubble.
  - in_flight is incremented on issue and decremented on lane_valid_out. Lane latency is 2 cycles.
  - After issuing bin HIST_MEM_DEPTH-1, go to DRAIN.
- DRAIN: hist_read and hist_rst stay asserted, lane_valid = 0. When in_flight = 0 and the FIFO is empty with the last beat accepted, pulse done and go to GAP.
- GAP: 1 cycle with lane_valid = 0 and hist_read = 0, so the first live event cannot alias the previous address. busy clears on entry to IDLE.
- Events: every evt_valid cycle while busy (QUIESCE..GAP) is dropped and increments dropped_events, which saturates at all-ones and is cleared only by reset.
- FIFO: stores {lane_last, lane_data} on lane_valid_out. Output is first-word fall-through. The credit scheme guarantees no overflow; overflow is an assertion failure.
- AXIS: tdata/tlast stay stable while tvalid && !tready.
- tlast: must equal (bin == HIST_MEM_DEPTH-1). A lane_last that arrives on a different beat is an assertion failure.
- start while busy: ignored, not queued.
- Reset mid-sweep: the FIFO is flushed and outputs return to reset values. Lane contents are then undefined; software re-clears.

Optional Feature:
HIST_READOUT_BIN_INDEX_EN
- Defined: adds output m_axis_tuser [HIST_MEM_ADDR_WIDTH-1:0] carrying the bin index of each beat. The index is stored in the FIFO alongside the data.
- Undefined: the port and storage are absent, and behaviour is otherwise identical.

Test Plan:
- HIST_MEM_DEPTH=16, tready=1. Increment bin 3 ×5 and bin 15 ×2, then start with clear=0 → 16 beats: beat3=5, beat15=2, others 0; tlast only on beat 15; done 1 cycle after that beat. A second readout returns identical values.
- Same fill, start with clear=1 → first readout returns 5/2; a second readout returns all zeros.
- tready toggles 1-of-3 cycles, FIFO_DEPTH=4 → no beat lost or duplicated, order 0..15, FIFO never exceeds 4, tdata stable while stalled.
- Events on bin 7 every cycle through a start → counts accepted before QUIESCE all appear in beat 7; dropped_events equals evt_valid cycles while busy; bin 7 counts again after GAP.
- Assert rst_n low at beat 6 → outputs 0 next cycle, busy=0, tvalid=0; a following start completes a full 16-beat readout.
- With HIST_READOUT_BIN_INDEX_EN defined → tuser = 0..15, matching beat order under backpressure.
